// File: rtl/add_carry_pkg.sv
// Shared types, default sizes and helpers for the add/carry pipeline.
package add_carry_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_ACC = 1'b1
  } mode_e;

  localparam int unsigned ADD_CARRY_WIDTH = 8;
  localparam int unsigned ADD_CARRY_CNT_W = 4;

  // Increment that sticks at max_val instead of wrapping.
  function automatic int unsigned sat_inc(input int unsigned cnt, input int unsigned max_val);
    return (cnt >= max_val) ? max_val : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/add_carry_bb_tap.sv
// Empty black-box tap cell kept as a bare instance in the netlist.
// Only compiled when BB_TAP_EN is defined.
`ifdef BB_TAP_EN
(* black_box *)
module add_carry_bb_tap (
  input logic in1,
  input logic in2,
  input logic clk
);
endmodule
`endif

// File: rtl/add_carry_pipe.sv
// Two-stage registered add/accumulate pipeline with valid/ready on both sides.
// Define BB_TAP_EN to add a black-box add_carry_bb_tap instance on cin/y[0].
module add_carry_pipe
  import add_carry_pkg::*;
#(
  parameter int unsigned WIDTH = ADD_CARRY_WIDTH,
  parameter int unsigned CNT_W = ADD_CARRY_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             mode,
  input  logic             clr_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a,
  output logic             cout,
  output logic [CNT_W-1:0] acc_cnt
);

  localparam int unsigned SW      = WIDTH + 1;
  localparam int unsigned CNT_MAX = (32'd1 << CNT_W) - 32'd1;

  logic             s1_valid;
  logic [SW-1:0]    s1_sum;
  logic [WIDTH-1:0] s1_y;
  mode_e            s1_mode;
  logic             s1_clr;
  logic [WIDTH-1:0] acc;

  logic             accept_c;
  logic             advance_c;
  logic [WIDTH-1:0] base_c;
  logic [SW-1:0]    sum_c;
  logic             carry_c;

  assign advance_c = s1_valid && (!out_valid || out_ready);
  assign in_ready  = !s1_valid || advance_c;
  assign accept_c  = in_valid && in_ready;

  // Stage-2 adder: ADD folds the stage-1 carry into cout, ACC reports only its own overflow.
  always_comb begin
    base_c  = '0;
    sum_c   = '0;
    carry_c = 1'b0;
    if (s1_mode == MODE_ACC) begin
      base_c  = s1_clr ? '0 : acc;
      sum_c   = {1'b0, base_c} + {1'b0, s1_sum[WIDTH-1:0]};
      carry_c = sum_c[WIDTH];
    end else begin
      sum_c   = {1'b0, s1_y} + {1'b0, s1_sum[WIDTH-1:0]};
      carry_c = sum_c[WIDTH] | s1_sum[WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sum    <= '0;
      s1_y      <= '0;
      s1_mode   <= MODE_ADD;
      s1_clr    <= 1'b0;
      out_valid <= 1'b0;
      a         <= '0;
      cout      <= 1'b0;
      acc       <= '0;
      acc_cnt   <= '0;
    end else begin
      if (accept_c) begin
        s1_sum   <= SW'(y) + SW'(cin);
        s1_y     <= y;
        s1_mode  <= mode_e'(mode);
        s1_clr   <= clr_acc;
        s1_valid <= 1'b1;
      end else if (advance_c) begin
        s1_valid <= 1'b0;
      end

      if (advance_c) begin
        out_valid <= 1'b1;
        a         <= sum_c[WIDTH-1:0];
        cout      <= carry_c;
        if (s1_mode == MODE_ACC) begin
          acc     <= sum_c[WIDTH-1:0];
          acc_cnt <= s1_clr ? CNT_W'(1) : CNT_W'(sat_inc(32'(acc_cnt), CNT_MAX));
        end else if (s1_clr) begin
          acc     <= '0;
          acc_cnt <= '0;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef BB_TAP_EN
  add_carry_bb_tap u_bb_tap (
    .in1 (cin),
    .in2 (y[0]),
    .clk (clk)
  );
`endif

endmodule

// File: tb/tb_add_carry_pipe.sv
// Directed self-checking bench for add_carry_pipe (8/4 instance and a 1/2 instance).
module tb_add_carry_pipe;

  logic       clk;
  logic       rst;

  logic       in_valid, in_ready, cin, mode, clr_acc, out_valid, out_ready, cout;
  logic [7:0] y, a;
  logic [3:0] acc_cnt;

  logic       in_valid1, in_ready1, cin1, mode1, clr_acc1, out_valid1, out_ready1, cout1;
  logic [0:0] y1, a1;
  logic [1:0] acc_cnt1;

  int tests;
  int fails;

  add_carry_pipe #(.WIDTH(8), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .y(y), .cin(cin),
    .mode(mode), .clr_acc(clr_acc), .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .cout(cout), .acc_cnt(acc_cnt)
  );

  add_carry_pipe #(.WIDTH(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .y(y1), .cin(cin1),
    .mode(mode1), .clr_acc(clr_acc1), .out_valid(out_valid1), .out_ready(out_ready1),
    .a(a1), .cout(cout1), .acc_cnt(acc_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [7:0] yv, input logic c, input logic m, input logic clr);
    int n;
    y = yv; cin = c; mode = m; clr_acc = clr; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL send0_timeout: got in_ready=%b exp 1", in_ready);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic send1(input logic yv, input logic c, input logic m, input logic clr);
    int n;
    y1 = yv; cin1 = c; mode1 = m; clr_acc1 = clr; in_valid1 = 1'b1;
    n = 0;
    while (!in_ready1 && n < 20) begin step(); n++; end
    if (!in_ready1) begin
      tests++; fails++;
      $display("FAIL send1_timeout: got in_ready=%b exp 1", in_ready1);
    end
    step();
    in_valid1 = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1; in_valid = 1'b0;
    step(); step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    tests++; if (a !== 8'h00) begin fails++; $display("FAIL reset_a: got %h exp 00", a); end
    tests++; if (cout !== 1'b0) begin fails++; $display("FAIL reset_cout: got %b exp 0", cout); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    tests++; if (acc_cnt !== 4'd0) begin fails++; $display("FAIL reset_acc_cnt: got %0d exp 0", acc_cnt); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
    tests++; if (out_valid1 !== 1'b0 || acc_cnt1 !== 2'd0) begin
      fails++; $display("FAIL reset_w1: got valid=%b cnt=%0d exp 0/0", out_valid1, acc_cnt1);
    end
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    send0(8'hFF, 1'b1, 1'b0, 1'b0);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL add_latency: got out_valid=%b exp 0 one cycle after accept", out_valid); end
    step();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL add_ff_valid: got %b exp 1", out_valid); end
    tests++; if (a !== 8'hFF) begin fails++; $display("FAIL add_ff_a: got %h exp ff", a); end
    tests++; if (cout !== 1'b1) begin fails++; $display("FAIL add_ff_cout: got %b exp 1", cout); end
    send0(8'h10, 1'b0, 1'b0, 1'b0);
    step();
    tests++; if (a !== 8'h20 || cout !== 1'b0) begin fails++; $display("FAIL add_10: got a=%h cout=%b exp 20/0", a, cout); end
    send0(8'h90, 1'b0, 1'b0, 1'b0);
    step();
    tests++; if (a !== 8'h20 || cout !== 1'b1) begin fails++; $display("FAIL add_90: got a=%h cout=%b exp 20/1", a, cout); end
    tests++; if (acc_cnt !== 4'd0) begin fails++; $display("FAIL add_cnt_hold: got %0d exp 0", acc_cnt); end
  endtask

  task automatic test_acc_wrap();
    out_ready = 1'b1;
    send0(8'h80, 1'b0, 1'b1, 1'b1);
    step();
    tests++; if (a !== 8'h80 || cout !== 1'b0 || acc_cnt !== 4'd1) begin
      fails++; $display("FAIL acc_first: got a=%h cout=%b cnt=%0d exp 80/0/1", a, cout, acc_cnt);
    end
    send0(8'h7F, 1'b1, 1'b1, 1'b0);
    step();
    tests++; if (a !== 8'h00 || cout !== 1'b1 || acc_cnt !== 4'd2) begin
      fails++; $display("FAIL acc_wrap: got a=%h cout=%b cnt=%0d exp 00/1/2", a, cout, acc_cnt);
    end
    send0(8'h01, 1'b0, 1'b0, 1'b0);
    step();
    tests++; if (a !== 8'h02 || acc_cnt !== 4'd2) begin
      fails++; $display("FAIL acc_add_between: got a=%h cnt=%0d exp 02/2", a, acc_cnt);
    end
    send0(8'h05, 1'b0, 1'b1, 1'b0);
    step();
    tests++; if (a !== 8'h05 || cout !== 1'b0 || acc_cnt !== 4'd3) begin
      fails++; $display("FAIL acc_persist: got a=%h cout=%b cnt=%0d exp 05/0/3", a, cout, acc_cnt);
    end
  endtask

  task automatic test_backpressure();
    int nacc, got;
    logic seen;
    logic [7:0] held;
    logic [7:0] r [2];
    drain();
    out_ready = 1'b0; mode = 1'b0; cin = 1'b0; clr_acc = 1'b0;
    nacc = 0; seen = 1'b0; held = '0; r[0] = '0; r[1] = '0;
    y = 8'd1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (in_ready) nacc++;
      step();
      y = 8'(nacc + 1);
      if (out_valid) begin
        if (!seen) begin
          held = a; seen = 1'b1;
        end else begin
          tests++; if (a !== held || cout !== 1'b0) begin
            fails++; $display("FAIL bp_stable: got a=%h cout=%b exp %h/0", a, cout, held);
          end
        end
      end
    end
    in_valid = 1'b0;
    tests++; if (nacc != 2) begin fails++; $display("FAIL bp_accepted: got %0d exp 2", nacc); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready: got %b exp 0", in_ready); end
    tests++; if (out_valid !== 1'b1 || a !== 8'h02) begin
      fails++; $display("FAIL bp_head: got valid=%b a=%h exp 1/02", out_valid, a);
    end
    out_ready = 1'b1; got = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) begin
        if (got < 2) r[got] = a;
        got++;
      end
      step();
    end
    tests++; if (got != 2) begin fails++; $display("FAIL bp_count: got %0d exp 2", got); end
    tests++; if (r[0] !== 8'h02 || r[1] !== 8'h04) begin
      fails++; $display("FAIL bp_order: got %h,%h exp 02,04", r[0], r[1]);
    end
  endtask

  task automatic test_back_to_back();
    int got, stall;
    logic [7:0] r [4];
    drain();
    mode = 1'b0; cin = 1'b0; clr_acc = 1'b0; got = 0; stall = 0;
    for (int k = 0; k < 4; k++) r[k] = '0;
    for (int i = 0; i < 8; i++) begin
      in_valid = (i < 4);
      y = (i < 4) ? 8'(i + 1) : 8'h00;
      if (in_valid && !in_ready) stall++;
      step();
      if (out_valid) begin
        if (got < 4) r[got] = a;
        got++;
      end
    end
    in_valid = 1'b0;
    tests++; if (stall != 0) begin fails++; $display("FAIL b2b_stall: got %0d stalls exp 0", stall); end
    tests++; if (got != 4) begin fails++; $display("FAIL b2b_count: got %0d exp 4", got); end
    tests++; if (r[0] !== 8'h02 || r[1] !== 8'h04 || r[2] !== 8'h06 || r[3] !== 8'h08) begin
      fails++; $display("FAIL b2b_data: got %h %h %h %h exp 02 04 06 08", r[0], r[1], r[2], r[3]);
    end
  endtask

  task automatic test_saturation();
    logic ea, ec;
    logic [1:0] en;
    out_ready1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send1(1'b1, 1'b0, 1'b1, (i == 0));
      step();
      ea = (i % 2 == 0);
      ec = (i % 2 == 1);
      en = (i >= 2) ? 2'd3 : 2'(i + 1);
      tests++; if (out_valid1 !== 1'b1 || a1 !== ea || cout1 !== ec || acc_cnt1 !== en) begin
        fails++;
        $display("FAIL sat_beat%0d: got v=%b a=%b cout=%b cnt=%0d exp 1/%b/%b/%0d",
                 i, out_valid1, a1, cout1, acc_cnt1, ea, ec, en);
      end
    end
    send1(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    tests++; if (a1 !== 1'b0 || cout1 !== 1'b1 || acc_cnt1 !== 2'd3) begin
      fails++; $display("FAIL sat_add_hold: got a=%b cout=%b cnt=%0d exp 0/1/3", a1, cout1, acc_cnt1);
    end
    send1(1'b0, 1'b1, 1'b0, 1'b1);
    step();
    tests++; if (a1 !== 1'b1 || cout1 !== 1'b0 || acc_cnt1 !== 2'd0) begin
      fails++; $display("FAIL sat_add_clr: got a=%b cout=%b cnt=%0d exp 1/0/0", a1, cout1, acc_cnt1);
    end
    send1(1'b1, 1'b0, 1'b1, 1'b0);
    step();
    tests++; if (a1 !== 1'b1 || cout1 !== 1'b0 || acc_cnt1 !== 2'd1) begin
      fails++; $display("FAIL sat_after_clr: got a=%b cout=%b cnt=%0d exp 1/0/1", a1, cout1, acc_cnt1);
    end
  endtask

  task automatic test_mid_reset();
    drain();
    out_ready = 1'b0; mode = 1'b1; cin = 1'b0;
    clr_acc = 1'b1; y = 8'h33; in_valid = 1'b1;
    step();
    clr_acc = 1'b0; y = 8'h11;
    step();
    tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || a !== 8'h33) begin
      fails++; $display("FAIL mr_full: got rdy=%b v=%b a=%h exp 0/1/33", in_ready, out_valid, a);
    end
    rst = 1'b1; out_ready = 1'b1; y = 8'h44;
    step();
    rst = 1'b0; in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0 || a !== 8'h00 || cout !== 1'b0 || acc_cnt !== 4'd0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL mr_cleared: got v=%b a=%h cout=%b cnt=%0d rdy=%b exp 0/00/0/0/1",
                        out_valid, a, cout, acc_cnt, in_ready);
    end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mr_dropped: got out_valid=%b exp 0", out_valid); end
    send0(8'h05, 1'b0, 1'b1, 1'b0);
    step();
    tests++; if (a !== 8'h05 || acc_cnt !== 4'd1) begin
      fails++; $display("FAIL mr_acc_zero: got a=%h cnt=%0d exp 05/1", a, acc_cnt);
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1;
    in_valid = 1'b0; y = '0; cin = 1'b0; mode = 1'b0; clr_acc = 1'b0; out_ready = 1'b0;
    in_valid1 = 1'b0; y1 = '0; cin1 = 1'b0; mode1 = 1'b0; clr_acc1 = 1'b0; out_ready1 = 1'b0;
    test_reset();
    test_add();
    test_acc_wrap();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
